// File: rtl/frame_tx_111.sv
// Serial frame transmitter: 111 marker, 0 guard, zero-stuffed MSB-first payload.
// Define PARITY_EN to append a stuffed even-parity bit after the payload.
module frame_tx_111 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              y_out,
  output logic              frame_active,
  output logic              done
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned RUN_W  = 2;
  localparam int unsigned MARK_W = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_GUARD = 3'd2,
    S_DATA  = 3'd3,
`ifdef PARITY_EN
    S_STUFF = 3'd4,
    S_PAR   = 3'd5
`else
    S_STUFF = 3'd4
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RUN_W-1:0]    ones_run_q, ones_run_d;
  logic [MARK_W-1:0]   mark_cnt_q, mark_cnt_d;
  logic                y_out_q, y_out_d;
  logic                frame_active_q, frame_active_d;
  logic                done_q, done_d;
`ifdef PARITY_EN
  logic                par_q, par_d;
  logic                par_sent_q, par_sent_d;
`endif

  logic                take_bit;
  logic                finish;
  logic                last_bit;
  logic [RUN_W-1:0]    ones_inc;

  assign last_bit = (bit_cnt_q == CNT_W'(DATA_W));
  assign ones_inc = (ones_run_q == RUN_W'(2)) ? RUN_W'(2) : ones_run_q + RUN_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      ones_run_q     <= '0;
      mark_cnt_q     <= '0;
      y_out_q        <= 1'b0;
      frame_active_q <= 1'b0;
      done_q         <= 1'b0;
`ifdef PARITY_EN
      par_q          <= 1'b0;
      par_sent_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      ones_run_q     <= ones_run_d;
      mark_cnt_q     <= mark_cnt_d;
      y_out_q        <= y_out_d;
      frame_active_q <= frame_active_d;
      done_q         <= done_d;
`ifdef PARITY_EN
      par_q          <= par_d;
      par_sent_q     <= par_sent_d;
`endif
    end
  end

  // Next state: state_q names the symbol currently on the line
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    ones_run_d = ones_run_q;
    mark_cnt_d = mark_cnt_q;
`ifdef PARITY_EN
    par_d      = par_q;
    par_sent_d = par_sent_q;
`endif
    take_bit   = 1'b0;
    finish     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_MARK;
          shreg_d    = data_in;
          bit_cnt_d  = '0;
          ones_run_d = '0;
          mark_cnt_d = '0;
`ifdef PARITY_EN
          par_d      = ^data_in;
          par_sent_d = 1'b0;
`endif
        end
      end
      S_MARK: begin
        if (mark_cnt_q == MARK_W'(2)) begin
          state_d    = S_GUARD;
          mark_cnt_d = '0;
        end else begin
          mark_cnt_d = mark_cnt_q + MARK_W'(1);
        end
      end
      S_GUARD: take_bit = 1'b1;
      S_DATA: begin
        if (ones_run_q == RUN_W'(2)) begin
          state_d    = S_STUFF;
          ones_run_d = '0;
        end else if (last_bit) begin
          finish = 1'b1;
        end else begin
          take_bit = 1'b1;
        end
      end
      S_STUFF: begin
        if (last_bit) begin
          finish = 1'b1;
        end else begin
          take_bit = 1'b1;
        end
      end
`ifdef PARITY_EN
      S_PAR: begin
        if (ones_run_q == RUN_W'(2)) begin
          state_d    = S_STUFF;
          ones_run_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Put the next payload bit on the line
    if (take_bit) begin
      state_d    = S_DATA;
      shreg_d    = shreg_q << 1;
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
      ones_run_d = shreg_q[DATA_W-1] ? ones_inc : '0;
    end

    // Payload (and its stuffing) exhausted
    if (finish) begin
`ifdef PARITY_EN
      if (par_sent_q) begin
        state_d = S_IDLE;
      end else begin
        state_d    = S_PAR;
        par_sent_d = 1'b1;
        ones_run_d = par_q ? ones_inc : '0;
      end
`else
      state_d = S_IDLE;
`endif
    end
  end

  // Registered outputs follow the symbol selected for the next cycle
  always_comb begin
    y_out_d        = 1'b0;
    frame_active_d = (state_d != S_IDLE);
    done_d         = (state_d == S_IDLE) && (state_q != S_IDLE);
    case (state_d)
      S_MARK:  y_out_d = 1'b1;
      S_DATA:  y_out_d = shreg_q[DATA_W-1];
`ifdef PARITY_EN
      S_PAR:   y_out_d = par_q;
`endif
      default: y_out_d = 1'b0;
    endcase
  end

  assign ready        = (state_q == S_IDLE);
  assign y_out        = y_out_q;
  assign frame_active = frame_active_q;
  assign done         = done_q;

endmodule

// File: tb/tb_frame_tx_111.sv
// Bench for frame_tx_111: frame-level queue model, 111 detector on y_out,
// directed frames with literal expectations (PARITY_EN aware).
module tb_frame_tx_111;
  localparam int unsigned DATA_W = 8;
  typedef bit bitq_t[$];

`ifdef PARITY_EN
  localparam logic [31:0] A5_BITS = 32'h1D4A;  localparam int A5_DONE = 14;
  localparam logic [31:0] FF_BITS = 32'h1DB6C; localparam int FF_DONE = 18;
  localparam logic [31:0] C6_BITS = 32'h7330;  localparam int C6_DONE = 16;
  localparam logic [31:0] S7_BITS = 32'h7036;  localparam int S7_DONE = 16;
  localparam logic [31:0] B2B_BITS = {4'b0, 13'h1D4A, 1'b0, 13'h1D4A, 1'b0};
  localparam int B2B_N = 28;
`else
  localparam logic [31:0] A5_BITS = 32'hEA5;   localparam int A5_DONE = 13;
  localparam logic [31:0] FF_BITS = 32'hEDB6;  localparam int FF_DONE = 17;
  localparam logic [31:0] C6_BITS = 32'h3998;  localparam int C6_DONE = 15;
  localparam logic [31:0] S7_BITS = 32'h1C0D;  localparam int S7_DONE = 14;
  localparam logic [31:0] B2B_BITS = {6'b0, 12'hEA5, 1'b0, 12'hEA5, 1'b0};
  localparam int B2B_N = 26;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic ready, y_out, frame_active, done;

  int n_vec = 0;
  int n_err = 0;

  always #2 clk = ~clk;

  frame_tx_111 #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready), .y_out(y_out), .frame_active(frame_active), .done(done)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Frame as it must appear on the line, built from the framing rules
  function automatic bitq_t build(input logic [7:0] d);
    bitq_t q;
    int run;
    bit p;
    q = '{1'b1, 1'b1, 1'b1, 1'b0};
    run = 0;
    p = ^d;
    for (int i = 7; i >= 0; i--) begin
      q.push_back(d[i]);
      run = d[i] ? run + 1 : 0;
      if (run == 2) begin q.push_back(1'b0); run = 0; end
    end
`ifdef PARITY_EN
    q.push_back(p);
    run = p ? run + 1 : 0;
    if (run == 2) q.push_back(1'b0);
`endif
    return q;
  endfunction

  function automatic logic [31:0] pack(input bitq_t q);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  // Reference 111 detector (Moore) listening to the line
  logic [1:0] det_run;
  logic       z;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_run <= 2'd0;
      z       <= 1'b0;
    end else begin
      det_run <= y_out ? ((det_run == 2'd3) ? 2'd3 : det_run + 2'd1) : 2'd0;
      z       <= y_out && (det_run >= 2'd2);
    end
  end

  // Model: queue of bits still to be sent, advanced on each clock
  bitq_t mq;
  bit    m_done = 1'b0;
  int    m_pos = 0;
  int    m_frames = 0;
  int    z_cnt = 0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      m_done = 1'b0;
      m_pos = 0;
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_done = (mq.size() == 0);
      m_pos = m_done ? 0 : m_pos + 1;
    end else begin
      m_done = 1'b0;
      if (start) begin
        mq = build(data_in);
        m_pos = 1;
        m_frames++;
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("y_out",        32'(y_out),        32'((mq.size() != 0) ? mq[0] : 1'b0));
    chk("frame_active", 32'(frame_active), 32'(mq.size() != 0));
    chk("ready",        32'(ready),        32'(mq.size() == 0));
    chk("done",         32'(done),         32'(m_done));
    chk("detector_z",   32'(z),            32'(m_pos == 4));
    if (z) z_cnt++;
  end

  task automatic wait_ready();
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] d, input int ncyc, input bit mid,
                           output logic [31:0] cap, output int dcyc);
    wait_ready();
    @(posedge clk); #1;
    start = 1'b1;
    data_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    cap = '0;
    dcyc = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (frame_active) cap = {cap[30:0], y_out};
      if (done && dcyc == 0) dcyc = c;
      @(posedge clk); #1;
      start = mid && (c == 2 || c == 7);
      data_in = 8'hFF;
    end
    start = 1'b0;
  endtask

  logic [31:0] cap;
  int          dcyc;
  int          ndone;
  int          z_before;

  initial begin
    // Model self-pins
    chk("model_A5", pack(build(8'hA5)), A5_BITS);
    chk("model_FF", pack(build(8'hFF)), FF_BITS);
    chk("model_07", pack(build(8'h07)), S7_BITS);

    // Reset held
    repeat (2) @(negedge clk);
    chk("rst_y_out", 32'(y_out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_frame(8'hA5, A5_DONE + 1, 1'b0, cap, dcyc);
    chk("A5_bits", cap, A5_BITS);
    chk("A5_done_cycle", 32'(dcyc), 32'(A5_DONE));

    run_frame(8'hFF, FF_DONE + 1, 1'b0, cap, dcyc);
    chk("FF_bits", cap, FF_BITS);
    chk("FF_done_cycle", 32'(dcyc), 32'(FF_DONE));

    run_frame(8'h6C, C6_DONE + 1, 1'b1, cap, dcyc);
    chk("6C_bits", cap, C6_BITS);
    chk("6C_done_cycle", 32'(dcyc), 32'(C6_DONE));

    run_frame(8'h07, S7_DONE + 1, 1'b0, cap, dcyc);
    chk("07_bits", cap, S7_BITS);
    chk("07_done_cycle", 32'(dcyc), 32'(S7_DONE));

    // Async reset in cycle 6 of an FF frame
    wait_ready();
    @(posedge clk); #1;
    start = 1'b1;
    data_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_y_out_before", 32'(y_out), 32'd1);
    chk("mid_active_before", 32'(frame_active), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_y_out", 32'(y_out), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_active", 32'(frame_active), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_frame(8'hFF, FF_DONE + 1, 1'b0, cap, dcyc);
    chk("FF_after_rst_bits", cap, FF_BITS);
    chk("FF_after_rst_done", 32'(dcyc), 32'(FF_DONE));

    // start held across done: back-to-back frames
    wait_ready();
    z_before = z_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    data_in = 8'hA5;
    @(posedge clk); #1;
    cap = '0;
    ndone = 0;
    for (int c = 1; c <= B2B_N; c++) begin
      @(negedge clk);
      cap = {cap[30:0], y_out};
      if (done) ndone++;
      @(posedge clk); #1;
      if (c == 20) start = 1'b0;
    end
    chk("b2b_bits", cap, B2B_BITS);
    chk("b2b_done_count", 32'(ndone), 32'd2);
    chk("b2b_z_count", 32'(z_cnt - z_before), 32'd2);

    repeat (3) @(negedge clk);
    chk("z_per_frame", 32'(z_cnt), 32'(m_frames));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
